rrf_freelist_manager: RTL and testbench

Allocates rename-register-file (RRF) entries to up to two destination registers per cycle at the rename stage. Supplies the physical tags that the renaming table writes into its map, with the corresponding busy bits set. Reclaims entries in order as instructions commit. Rolls the allocation pointer back on branch misprediction. RRF is a circular buffer: entries are allocated at rrf_ptr and freed at com_ptr.

---
 rtl/rrf_freelist_manager_pkg.sv | 14 +
 rtl/rrf_freelist_manager.sv | 91 +++++++++
 tb/tb_rrf_freelist_manager.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rrf_freelist_manager_pkg.sv
// Shared constants for the rename register file free list.
// Widths of tags, free counts and per-cycle allocation numbers.
package rrf_freelist_manager_pkg;

    localparam int RRF_NUM     = 64;
    localparam int RRF_SEL     = 6;
    localparam int ALLOC_NUM_W = 2;

    typedef logic [RRF_SEL-1:0] rrf_tag_t;
    typedef logic [RRF_SEL:0]   rrf_cnt_t;

    localparam rrf_cnt_t RRF_FULL = rrf_cnt_t'(RRF_NUM);

endpackage

// File: rtl/rrf_freelist_manager.sv
// Circular-buffer free list for RRF entries: allocates up to two tags
// per cycle, frees in commit order and rolls back on mispredict.
module rrf_freelist_manager
    import rrf_freelist_manager_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ALLOC_NUM_W-1:0] req_num_i,
    input  logic                   stall_dp_i,
    input  logic [ALLOC_NUM_W-1:0] com_num_i,
    input  logic                   prmiss_i,
    input  logic [RRF_SEL-1:0]     rrftag_fix_i,
    output logic [RRF_SEL-1:0]     rrftag1_o,
    output logic [RRF_SEL-1:0]     rrftag2_o,
    output logic                   stall_o,
    output logic [RRF_SEL:0]       free_num_o,
    output logic [RRF_SEL-1:0]     rrf_ptr_o,
    output logic [RRF_SEL-1:0]     com_ptr_o,
    output logic                   nextrrfcyc_o
);

    rrf_tag_t rrf_ptr;
    rrf_tag_t com_ptr;
    rrf_cnt_t free_num;
    logic     nextrrfcyc;

    logic [ALLOC_NUM_W-1:0] alloc_num;
    rrf_cnt_t               alloc_ext;
    rrf_cnt_t               req_ext;
    rrf_cnt_t               com_ext;
    rrf_cnt_t               used_num;
    rrf_cnt_t               com_eff;
    rrf_cnt_t               ptr_sum;
    rrf_tag_t               com_ptr_n;
    rrf_tag_t               fix_dist;
    rrf_cnt_t               fix_occ;
    rrf_tag_t               ptr_diff;

    assign req_ext   = rrf_cnt_t'(req_num_i);
    assign com_ext   = rrf_cnt_t'(com_num_i);
    assign stall_o   = req_ext > free_num;
    assign alloc_num = (stall_o || stall_dp_i || prmiss_i) ? '0 : req_num_i;
    assign alloc_ext = rrf_cnt_t'(alloc_num);

    // Commits never free more entries than are live, so an empty
    // list keeps com_ptr still and free_num saturated.
    assign used_num  = RRF_FULL - free_num;
    assign com_eff   = (com_ext > used_num) ? used_num : com_ext;
    assign com_ptr_n = com_ptr + com_eff[RRF_SEL-1:0];

    assign ptr_sum   = {1'b0, rrf_ptr} + alloc_ext;

    // Live entries after recovery span com_ptr_n through the branch.
    assign fix_dist  = rrftag_fix_i - com_ptr_n;
    assign fix_occ   = {1'b0, fix_dist} + 1'b1;

    assign rrftag1_o    = rrf_ptr;
    assign rrftag2_o    = rrf_ptr + 1'b1;
    assign free_num_o   = free_num;
    assign rrf_ptr_o    = rrf_ptr;
    assign com_ptr_o    = com_ptr;
    assign nextrrfcyc_o = nextrrfcyc;

    // Pointer, phase and free-count update; recovery overrides allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            rrf_ptr    <= '0;
            com_ptr    <= '0;
            free_num   <= RRF_FULL;
            nextrrfcyc <= 1'b0;
        end else if (prmiss_i) begin
            rrf_ptr    <= rrftag_fix_i + 1'b1;
            com_ptr    <= com_ptr_n;
            free_num   <= RRF_FULL - fix_occ;
            nextrrfcyc <= nextrrfcyc ^ (rrftag_fix_i >= rrf_ptr);
        end else begin
            rrf_ptr    <= ptr_sum[RRF_SEL-1:0];
            com_ptr    <= com_ptr_n;
            free_num   <= free_num - alloc_ext + com_eff;
            nextrrfcyc <= nextrrfcyc ^ ptr_sum[RRF_SEL];
        end
    end

    assign ptr_diff = rrf_ptr - com_ptr;

    // Free count and pointer distance must always account for every entry.
    a_occupancy : assert property (@(posedge clk) disable iff (reset)
        (free_num == '0) ? (rrf_ptr == com_ptr)
                         : ((free_num + {1'b0, ptr_diff}) == RRF_FULL));

endmodule

// File: tb/tb_rrf_freelist_manager.sv
// Directed bench for rrf_freelist_manager with hand-computed vectors.
// One task per scenario; each checks its own outputs inline.
module tb_rrf_freelist_manager;
    import rrf_freelist_manager_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_num_i = '0;
    logic       stall_dp_i = 1'b0;
    logic [1:0] com_num_i = '0;
    logic       prmiss_i = 1'b0;
    logic [5:0] rrftag_fix_i = '0;
    logic [5:0] rrftag1_o, rrftag2_o, rrf_ptr_o, com_ptr_o;
    logic       stall_o, nextrrfcyc_o;
    logic [6:0] free_num_o;

    int vectors = 0;
    int miscompares = 0;

    rrf_freelist_manager dut (
        .clk          (clk),
        .reset        (reset),
        .req_num_i    (req_num_i),
        .stall_dp_i   (stall_dp_i),
        .com_num_i    (com_num_i),
        .prmiss_i     (prmiss_i),
        .rrftag_fix_i (rrftag_fix_i),
        .rrftag1_o    (rrftag1_o),
        .rrftag2_o    (rrftag2_o),
        .stall_o      (stall_o),
        .free_num_o   (free_num_o),
        .rrf_ptr_o    (rrf_ptr_o),
        .com_ptr_o    (com_ptr_o),
        .nextrrfcyc_o (nextrrfcyc_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] c);
        req_num_i = r;
        com_num_i = c;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'd0, 2'd0);
        stall_dp_i = 1'b0;
        prmiss_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (rrf_ptr_o !== 6'd0) begin miscompares++; $display("FAIL rst_rrf_ptr got %0d exp 0", rrf_ptr_o); end
        vectors++; if (com_ptr_o !== 6'd0) begin miscompares++; $display("FAIL rst_com_ptr got %0d exp 0", com_ptr_o); end
        vectors++; if (free_num_o !== 7'd64) begin miscompares++; $display("FAIL rst_free got %0d exp 64", free_num_o); end
        vectors++; if (nextrrfcyc_o !== 1'b0) begin miscompares++; $display("FAIL rst_cyc got %0b exp 0", nextrrfcyc_o); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %0b exp 0", stall_o); end
        vectors++; if (rrftag2_o !== 6'd1) begin miscompares++; $display("FAIL rst_tag2 got %0d exp 1", rrftag2_o); end
    endtask

    task automatic test_alloc_pairs();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2'd2, 2'd0);
            vectors++; if (rrftag1_o !== 6'(2*i)) begin miscompares++; $display("FAIL pair_tag1[%0d] got %0d exp %0d", i, rrftag1_o, 2*i); end
            vectors++; if (rrftag2_o !== 6'(2*i+1)) begin miscompares++; $display("FAIL pair_tag2[%0d] got %0d exp %0d", i, rrftag2_o, 2*i+1); end
            vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL pair_stall[%0d] got %0b exp 0", i, stall_o); end
            tick();
        end
        drive(2'd0, 2'd0);
        vectors++; if (free_num_o !== 7'd58) begin miscompares++; $display("FAIL pair_free got %0d exp 58", free_num_o); end
        vectors++; if (rrf_ptr_o !== 6'd6) begin miscompares++; $display("FAIL pair_rrf_ptr got %0d exp 6", rrf_ptr_o); end
    endtask

    task automatic fill_to_one();
        do_reset();
        for (int i = 0; i < 31; i++) begin
            drive(2'd2, 2'd0);
            tick();
        end
        drive(2'd1, 2'd0);
        tick();
        drive(2'd0, 2'd0);
    endtask

    task automatic test_fill();
        fill_to_one();
        vectors++; if (free_num_o !== 7'd1) begin miscompares++; $display("FAIL fill_free1 got %0d exp 1", free_num_o); end
        drive(2'd2, 2'd0);
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL fill_stall got %0b exp 1", stall_o); end
        tick();
        vectors++; if (rrf_ptr_o !== 6'd63) begin miscompares++; $display("FAIL fill_hold_ptr got %0d exp 63", rrf_ptr_o); end
        drive(2'd1, 2'd0);
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL fill_last_stall got %0b exp 0", stall_o); end
        vectors++; if (rrftag1_o !== 6'd63) begin miscompares++; $display("FAIL fill_tag1 got %0d exp 63", rrftag1_o); end
        vectors++; if (rrftag2_o !== 6'd0) begin miscompares++; $display("FAIL fill_tag2 got %0d exp 0", rrftag2_o); end
        tick();
        drive(2'd0, 2'd0);
        vectors++; if (free_num_o !== 7'd0) begin miscompares++; $display("FAIL fill_free0 got %0d exp 0", free_num_o); end
        vectors++; if (rrf_ptr_o !== 6'd0) begin miscompares++; $display("FAIL fill_ptr_wrap got %0d exp 0", rrf_ptr_o); end
        vectors++; if (nextrrfcyc_o !== 1'b1) begin miscompares++; $display("FAIL fill_cyc got %0b exp 1", nextrrfcyc_o); end
    endtask

    task automatic test_simultaneous();
        drive(2'd1, 2'd0);
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL full_req1_stall got %0b exp 1", stall_o); end
        drive(2'd2, 2'd2);
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL sim_stall got %0b exp 1", stall_o); end
        tick();
        drive(2'd0, 2'd0);
        vectors++; if (free_num_o !== 7'd2) begin miscompares++; $display("FAIL sim_free got %0d exp 2", free_num_o); end
        vectors++; if (com_ptr_o !== 6'd2) begin miscompares++; $display("FAIL sim_com_ptr got %0d exp 2", com_ptr_o); end
        vectors++; if (rrf_ptr_o !== 6'd0) begin miscompares++; $display("FAIL sim_rrf_ptr got %0d exp 0", rrf_ptr_o); end
        drive(2'd2, 2'd0);
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL sim_next_stall got %0b exp 0", stall_o); end
        tick();
        drive(2'd0, 2'd0);
        vectors++; if (rrf_ptr_o !== 6'd2) begin miscompares++; $display("FAIL sim_next_ptr got %0d exp 2", rrf_ptr_o); end
        vectors++; if (free_num_o !== 7'd0) begin miscompares++; $display("FAIL sim_next_free got %0d exp 0", free_num_o); end
    endtask

    task automatic test_wrap();
        fill_to_one();
        for (int i = 0; i < 5; i++) begin
            drive(2'd0, 2'd2);
            tick();
        end
        drive(2'd2, 2'd0);
        vectors++; if (com_ptr_o !== 6'd10) begin miscompares++; $display("FAIL wrap_com_ptr got %0d exp 10", com_ptr_o); end
        vectors++; if (rrftag1_o !== 6'd63) begin miscompares++; $display("FAIL wrap_tag1 got %0d exp 63", rrftag1_o); end
        vectors++; if (rrftag2_o !== 6'd0) begin miscompares++; $display("FAIL wrap_tag2 got %0d exp 0", rrftag2_o); end
        vectors++; if (nextrrfcyc_o !== 1'b0) begin miscompares++; $display("FAIL wrap_cyc_pre got %0b exp 0", nextrrfcyc_o); end
        tick();
        drive(2'd0, 2'd0);
        vectors++; if (rrf_ptr_o !== 6'd1) begin miscompares++; $display("FAIL wrap_ptr got %0d exp 1", rrf_ptr_o); end
        vectors++; if (nextrrfcyc_o !== 1'b1) begin miscompares++; $display("FAIL wrap_cyc got %0b exp 1", nextrrfcyc_o); end
        vectors++; if (free_num_o !== 7'd9) begin miscompares++; $display("FAIL wrap_free got %0d exp 9", free_num_o); end
    endtask

    task automatic test_empty_commit();
        do_reset();
        drive(2'd0, 2'd2);
        tick();
        drive(2'd0, 2'd0);
        vectors++; if (free_num_o !== 7'd64) begin miscompares++; $display("FAIL empty_free got %0d exp 64", free_num_o); end
        vectors++; if (com_ptr_o !== 6'd0) begin miscompares++; $display("FAIL empty_com_ptr got %0d exp 0", com_ptr_o); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(2'd2, 2'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(2'd0, 2'd2);
            tick();
        end
        drive(2'd2, 2'd1);
        prmiss_i = 1'b1;
        rrftag_fix_i = 6'd9;
        #1;
        vectors++; if (rrf_ptr_o !== 6'd20) begin miscompares++; $display("FAIL mp_pre_ptr got %0d exp 20", rrf_ptr_o); end
        tick();
        prmiss_i = 1'b0;
        drive(2'd0, 2'd0);
        vectors++; if (rrf_ptr_o !== 6'd10) begin miscompares++; $display("FAIL mp_rrf_ptr got %0d exp 10", rrf_ptr_o); end
        vectors++; if (com_ptr_o !== 6'd5) begin miscompares++; $display("FAIL mp_com_ptr got %0d exp 5", com_ptr_o); end
        vectors++; if (free_num_o !== 7'd59) begin miscompares++; $display("FAIL mp_free got %0d exp 59", free_num_o); end
        vectors++; if (nextrrfcyc_o !== 1'b0) begin miscompares++; $display("FAIL mp_cyc got %0b exp 0", nextrrfcyc_o); end
    endtask

    task automatic test_stall_dp_and_reset();
        stall_dp_i = 1'b1;
        drive(2'd2, 2'd0);
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL dp_stall got %0b exp 0", stall_o); end
        tick();
        stall_dp_i = 1'b0;
        drive(2'd0, 2'd0);
        vectors++; if (rrf_ptr_o !== 6'd10) begin miscompares++; $display("FAIL dp_ptr got %0d exp 10", rrf_ptr_o); end
        vectors++; if (free_num_o !== 7'd59) begin miscompares++; $display("FAIL dp_free got %0d exp 59", free_num_o); end
        reset = 1'b1;
        drive(2'd2, 2'd1);
        tick();
        reset = 1'b0;
        drive(2'd0, 2'd0);
        vectors++; if (rrf_ptr_o !== 6'd0) begin miscompares++; $display("FAIL mrst_ptr got %0d exp 0", rrf_ptr_o); end
        vectors++; if (com_ptr_o !== 6'd0) begin miscompares++; $display("FAIL mrst_com got %0d exp 0", com_ptr_o); end
        vectors++; if (free_num_o !== 7'd64) begin miscompares++; $display("FAIL mrst_free got %0d exp 64", free_num_o); end
        vectors++; if (nextrrfcyc_o !== 1'b0) begin miscompares++; $display("FAIL mrst_cyc got %0b exp 0", nextrrfcyc_o); end
    endtask

    initial begin
        test_reset();
        test_alloc_pairs();
        test_fill();
        test_simultaneous();
        test_wrap();
        test_empty_commit();
        test_mispredict();
        test_stall_dp_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
